// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_t;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam int         LANES   = 4;

endpackage

// File: rtl/byte_lane_fmt.sv
// Byte-lane steering for the data port: store-side enables/replication and
// load-side lane select with sign extension (lb semantics).
module byte_lane_fmt
  import mem_arb_pkg::*;
(
  input  logic                 st_worb,
  input  logic [1:0]           st_off,
  input  logic [LANES*8-1:0]   st_wdata,
  output logic [LANES-1:0]     st_be,
  output logic [LANES*8-1:0]   st_data,
  input  logic                 ld_worb,
  input  logic [1:0]           ld_off,
  input  logic [LANES*8-1:0]   ld_rdata,
  output logic [LANES*8-1:0]   ld_data
);

  function automatic logic [LANES*8-1:0] sext_lane(input logic [LANES*8-1:0] word,
                                                   input logic [1:0] off);
    logic signed [7:0]         lane;
    logic signed [LANES*8-1:0] ext;
    case (off)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      default: lane = word[31:24];
    endcase
    ext = lane;
    return ext;
  endfunction

  // Store path: word writes pass through, byte writes replicate the low byte
  // to every lane and let the enable pick the target lane.
  always_comb begin
    st_be   = BE_WORD;
    st_data = st_wdata;
    if (!st_worb) begin
      st_be   = 4'b0001 << st_off;
      st_data = {LANES{st_wdata[7:0]}};
    end
  end

  // Load path: uses the size/offset captured at issue, not the live request.
  always_comb begin
    ld_data = ld_worb ? ld_rdata : sext_lane(ld_rdata, ld_off);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported synchronous-read memory between the fetch and
// data ports of the core; one access outstanding, data wins ties, and a
// port's own completion cycle hands priority to the other port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_worb,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_misalign,
  output logic          stall_if,
  output logic          stall_d,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t      state, state_next;
  logic            issue_if, issue_d;
  logic            if_vld_p1, d_vld_p1, mis_p1;
  logic [1:0]      off_p1;
  logic            worb_p1;
  logic [3:0]      st_be;
  logic [DW-1:0]   st_data;
  logic [DW-1:0]   ld_data;
  logic            unused_if_lsb;

  assign unused_if_lsb = ^if_addr[1:0];

  byte_lane_fmt u_fmt (
    .st_worb  (d_worb),
    .st_off   (d_addr[1:0]),
    .st_wdata (d_wdata),
    .st_be    (st_be),
    .st_data  (st_data),
    .ld_worb  (worb_p1),
    .ld_off   (off_p1),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

  // Eligibility, priority, next state and the combinational memory command.
  always_comb begin
    issue_d    = !reset && d_req && (state != D_WAIT);
    issue_if   = !reset && if_req && (state != I_WAIT) && !issue_d;
    state_next = IDLE;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'h0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (issue_d) begin
      state_next = D_WAIT;
      mem_en     = 1'b1;
      mem_we     = d_we;
      mem_be     = st_be;
      mem_addr   = {d_addr[AW-1:2], 2'b00};
      mem_wdata  = st_data;
    end else if (issue_if) begin
      state_next = I_WAIT;
      mem_en     = 1'b1;
      mem_be     = BE_WORD;
      mem_addr   = {if_addr[AW-1:2], 2'b00};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Issue -> completion: response tags one cycle behind the issue decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_vld_p1 <= 1'b0;
      d_vld_p1  <= 1'b0;
      mis_p1    <= 1'b0;
    end else begin
      if_vld_p1 <= issue_if;
      d_vld_p1  <= issue_d;
      mis_p1    <= issue_d && d_worb && (d_addr[1:0] != 2'b00);
    end
  end

  // Load formatting tags captured at data issue.
  always_ff @(posedge clk) begin
    if (issue_d) begin
      off_p1  <= d_addr[1:0];
      worb_p1 <= d_worb;
    end
  end

  // Responses; reset suppresses any completion still in flight.
  always_comb begin
    if_valid   = if_vld_p1 && !reset;
    d_valid    = d_vld_p1 && !reset;
    d_misalign = mis_p1 && !reset;
    if_rdata   = if_valid ? mem_rdata : '0;
    d_rdata    = d_valid ? ld_data : '0;
    stall_if   = if_req && !if_valid;
    stall_d    = d_req && !d_valid;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req, d_we, d_worb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_valid, d_misalign, stall_if, stall_d;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_worb(d_worb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .d_misalign(d_misalign), .stall_if(stall_if), .stall_d(stall_d),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: preset contents under reset, byte-enabled writes, 1-cycle reads.
  always @(posedge clk) begin
    if (reset) begin
      mem[4]  <= 32'h2402_0005;
      mem[8]  <= 32'h1180_FF00;
      mem[16] <= 32'hCAFE_F00D;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_worb = 1'b1; d_addr = 32'h0; d_wdata = 32'h0;
    tick(); tick();
    smp();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    // Fetch only, held four cycles.
    tick(); reset = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    smp();
    chk("f0_mem_en", {31'b0, mem_en}, 32'd1);
    chk("f0_mem_addr", mem_addr, 32'h10);
    chk("f0_mem_be", {28'b0, mem_be}, 32'hF);
    chk("f0_mem_we", {31'b0, mem_we}, 32'd0);
    chk("f0_stall_if", {31'b0, stall_if}, 32'd1);
    chk("f0_if_valid", {31'b0, if_valid}, 32'd0);
    tick(); smp();
    chk("f1_if_valid", {31'b0, if_valid}, 32'd1);
    chk("f1_if_rdata", if_rdata, 32'h2402_0005);
    chk("f1_mem_en", {31'b0, mem_en}, 32'd0);
    chk("f1_stall_if", {31'b0, stall_if}, 32'd0);
    tick(); smp();
    chk("f2_mem_en", {31'b0, mem_en}, 32'd1);
    chk("f2_stall_if", {31'b0, stall_if}, 32'd1);
    chk("f2_if_valid", {31'b0, if_valid}, 32'd0);
    tick(); smp();
    chk("f3_if_valid", {31'b0, if_valid}, 32'd1);
    tick(); if_req = 1'b0;
    smp();
    chk("f4_mem_en", {31'b0, mem_en}, 32'd0);
    chk("f4_if_valid", {31'b0, if_valid}, 32'd0);

    // Both ports requesting from IDLE, then held to alternate.
    tick(); if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_worb = 1'b1; d_addr = 32'h20;
    smp();
    chk("b0_mem_addr", mem_addr, 32'h20);
    chk("b0_stall_d", {31'b0, stall_d}, 32'd1);
    chk("b0_stall_if", {31'b0, stall_if}, 32'd1);
    tick(); smp();
    chk("b1_d_valid", {31'b0, d_valid}, 32'd1);
    chk("b1_d_rdata", d_rdata, 32'h1180_FF00);
    chk("b1_if_valid", {31'b0, if_valid}, 32'd0);
    chk("b1_mem_addr", mem_addr, 32'h10);
    tick(); smp();
    chk("b2_if_valid", {31'b0, if_valid}, 32'd1);
    chk("b2_if_rdata", if_rdata, 32'h2402_0005);
    chk("b2_d_valid", {31'b0, d_valid}, 32'd0);
    chk("b2_mem_addr", mem_addr, 32'h20);
    tick(); smp();
    chk("b3_d_valid", {31'b0, d_valid}, 32'd1);
    chk("b3_mem_addr", mem_addr, 32'h10);
    tick(); d_req = 1'b0;
    smp();
    chk("b4_if_valid", {31'b0, if_valid}, 32'd1);
    chk("b4_mem_en", {31'b0, mem_en}, 32'd0);
    tick(); if_req = 1'b0;
    smp();
    chk("b5_mem_en", {31'b0, mem_en}, 32'd0);

    // Byte store to lane 3 of word 0x20.
    tick(); d_req = 1'b1; d_we = 1'b1; d_worb = 1'b0; d_addr = 32'h23; d_wdata = 32'h0000_00A5;
    smp();
    chk("s0_mem_addr", mem_addr, 32'h20);
    chk("s0_mem_be", {28'b0, mem_be}, 32'h8);
    chk("s0_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("s0_mem_we", {31'b0, mem_we}, 32'd1);
    tick(); smp();
    chk("s1_d_valid", {31'b0, d_valid}, 32'd1);
    chk("s1_d_misalign", {31'b0, d_misalign}, 32'd0);
    chk("s1_mem_en", {31'b0, mem_en}, 32'd0);
    tick(); d_req = 1'b0; d_we = 1'b0;
    smp();

    // Byte loads, then word loads (aligned and misaligned).
    tick(); d_req = 1'b1; d_worb = 1'b0; d_addr = 32'h22;
    smp();
    chk("l0_mem_addr", mem_addr, 32'h20);
    tick(); smp();
    chk("l1_d_valid", {31'b0, d_valid}, 32'd1);
    chk("l1_d_rdata", d_rdata, 32'hFFFF_FF80);
    tick(); d_addr = 32'h21;
    smp();
    chk("l2_mem_en", {31'b0, mem_en}, 32'd1);
    tick(); smp();
    chk("l3_d_rdata", d_rdata, 32'hFFFF_FFFF);
    tick(); d_worb = 1'b1; d_addr = 32'h20;
    smp();
    tick(); smp();
    chk("l5_d_rdata", d_rdata, 32'hA580_FF00);
    chk("l5_d_misalign", {31'b0, d_misalign}, 32'd0);
    tick(); d_addr = 32'h42;
    smp();
    chk("l6_mem_addr", mem_addr, 32'h40);
    tick(); smp();
    chk("l7_d_valid", {31'b0, d_valid}, 32'd1);
    chk("l7_d_misalign", {31'b0, d_misalign}, 32'd1);
    chk("l7_d_rdata", d_rdata, 32'hCAFE_F00D);
    tick(); d_req = 1'b0;
    smp();
    chk("l8_d_misalign", {31'b0, d_misalign}, 32'd0);

    // Reset while a data access is outstanding.
    tick(); d_req = 1'b1; d_worb = 1'b1; d_addr = 32'h40;
    smp();
    chk("r0_mem_en", {31'b0, mem_en}, 32'd1);
    tick(); reset = 1'b1; d_req = 1'b0;
    smp();
    chk("r1_d_valid", {31'b0, d_valid}, 32'd0);
    chk("r1_mem_en", {31'b0, mem_en}, 32'd0);
    chk("r1_d_rdata", d_rdata, 32'd0);
    tick(); reset = 1'b0;
    smp();
    chk("r2_d_valid", {31'b0, d_valid}, 32'd0);
    chk("r2_mem_en", {31'b0, mem_en}, 32'd0);
    chk("r2_mem_addr", mem_addr, 32'd0);
    tick(); d_req = 1'b1;
    smp();
    chk("r3_mem_en", {31'b0, mem_en}, 32'd1);
    chk("r3_mem_addr", mem_addr, 32'h40);
    tick(); smp();
    chk("r4_d_valid", {31'b0, d_valid}, 32'd1);
    chk("r4_d_rdata", d_rdata, 32'hCAFE_F00D);
    tick(); d_req = 1'b0;
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, synchronous-read unified memory between the pipelined MIPS core's instruction-fetch port and its data (load/store) port. Sits between the `mips` core and the unified memory, replacing separate instruction and data memories. It arbitrates each cycle, sequences one memory access at a time, steers byte/word lanes for the `worb` access size, and returns read data with a valid strobe. The core stalls on the stall outputs.

## Interface
- `AW`, 32, byte-address width
- `DW`, 32, data width (fixed 32; 4 byte lanes)
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `if_req` in 1: fetch request, level, held until `if_valid`
- `if_addr` in AW: fetch byte address, word-aligned
- `if_rdata` out DW: instruction, meaningful when `if_valid`
- `if_valid` out 1: fetch completion pulse
- `d_req` in 1: data request, level, held until `d_valid`
- `d_we` in 1: 1 = store, 0 = load
- `d_worb` in 1: 1 = word, 0 = byte
- `d_addr` in AW: data byte address
- `d_wdata` in DW: store data; byte store uses [7:0]
- `d_rdata` out DW: load data, meaningful when `d_valid`
- `d_valid` out 1: data completion pulse, also pulsed for stores
- `d_misalign` out 1: pulses with `d_valid` for a word access with `d_addr[1:0]!=0`
- `stall_if` out 1: `if_req && !if_valid`
- `stall_d` out 1: `d_req && !d_valid`
- `mem_en` out 1: memory access this cycle
- `mem_we` out 1: write enable
- `mem_be` out 4: byte enables, bit i = lane [8i+7:8i]
- `mem_addr` out AW: word address, with [1:0] forced to 0
- `mem_wdata` out DW: lane-steered write data
- `mem_rdata` in DW: read data, valid the cycle after a read `mem_en`

## Operation
- States: IDLE, I_WAIT (fetch outstanding), D_WAIT (data outstanding). At most one access is outstanding.
- Issue is decided combinationally from the state and the requests. The `mem_*` outputs are driven in the issue cycle, and the next state is the WAIT for the issued port.
- Eligibility:
  - In IDLE, both ports are eligible.
  - In I_WAIT, only `d_req` is eligible.
  - In D_WAIT, only `if_req` is eligible.
  - A port's request in its own completion cycle is the request being completed. It is ignored.
- Priority: data beats fetch when both are eligible. The completion-cycle rule makes the ports alternate under contention, so there is no starvation.
- WAIT state with no eligible request: go to IDLE. WAIT state with an eligible request: issue it and go to that WAIT (back-to-back).
- A requester that keeps `req` high in the cycle after its valid has made a new request.
- Fetch: `mem_be`=4'hF and `mem_we`=0. `if_rdata` = `mem_rdata`.
- Word store: `mem_be`=4'hF and `mem_wdata`=`d_wdata`.
- Byte store: `mem_be` = 1<<`d_addr[1:0]`, and `mem_wdata` = `d_wdata[7:0]` replicated ×4.
- Word load: `d_rdata` = `mem_rdata`.
- Byte load: lane `d_addr[1:0]` sign-extended to 32 bits, matching `lb`. The lane offset is registered at issue.
- Misaligned word access: performed at the aligned word, with `d_misalign` pulsed. There is no trap.
- Reset, including mid-access:
  - State goes to IDLE.
  - The outstanding response is discarded, and no valid is emitted for it.
  - While `reset` is high, `mem_en`=`mem_we`=0.

## Timing
- Reset values:
  - `if_valid`, `d_valid`, `d_misalign`, `mem_en`, `mem_we` = 0.
  - `mem_be`=0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - `stall_*` follow their equations.
- Latency:
  - Request to valid is 1 cycle when issued immediately.
  - Valid is asserted in the cycle after issue, for exactly 1 cycle.
  - `*_rdata` is combinational from `mem_rdata` in that cycle.
- Throughput: 1 access/cycle when the ports alternate. A single port alone gets 1 access per 2 cycles.
- Simultaneous requests in IDLE at cycle 0:
  - Data issues at 0, and `d_valid` at 1.
  - Fetch issues at 1, and `if_valid` at 2.
- Stores write at the issue edge. `d_valid` follows 1 cycle later.
- Registered outputs: state, valids, `d_misalign`, the latched byte offset and the latched `d_worb`. The `mem_*` outputs are combinational.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, I_WAIT, D_WAIT}
  - `BE_WORD`=4'hF
  - `LANES`=4
- Sub-module `byte_lane_fmt`, purely combinational:
  - Store path: size and offset in → `mem_be`/`mem_wdata` out.
  - Load path: latched size and offset plus `mem_rdata` in → `d_rdata` out.
- The top holds the FSM, eligibility/priority logic and the registered response tags.

## Test plan
- Fetch only, `if_addr`=0x10 held 4 cycles → `mem_en` at cycles 0 and 2, `if_valid` at 1 and 3, `if_rdata`=mem[0x10]. `stall_if` is 1 at cycles 0 and 2.
- Both requests in IDLE → data issued at cycle 0 and fetch at cycle 1. `d_valid` at 1, `if_valid` at 2. Then with both held, they alternate every cycle.
- Byte store, `d_addr`=0x23, `d_wdata`=0x000000A5 → `mem_addr`=0x20, `mem_be`=4'b1000, `mem_wdata`=0xA5A5A5A5. `d_valid` next cycle.
- Byte load, `d_addr`=0x22, memory word 0x1180FF00 → `d_rdata`=0xFFFFFF80. With `d_addr`=0x21 → `d_rdata`=0xFFFFFFFF.
- Word load, `d_addr`=0x42 → `mem_addr`=0x40, and `d_misalign`=1 with `d_valid`.
- `reset` asserted in D_WAIT → no `d_valid`. All outputs are at reset values next cycle. The first request after reset issues normally.
